// File: rtl/ahb_slave_mem.sv
// Word-addressed AHB slave RAM with programmable wait states,
// two-cycle ERROR/RETRY/SPLIT responses and HSPLIT release.
module ahb_slave_mem #(
  parameter int ADDR_W      = 6,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0,
  parameter bit SPLIT_EN    = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic [3:0]  HMASTER,
  input  logic        HREADY,
  input  logic        split_busy,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [15:0] HSPLIT
);

  typedef enum logic [1:0] {
    ST_READY,
    ST_WAIT,
    ST_RESP1,
    ST_RESP2
  } state_e;

  localparam logic [1:0] R_OKAY  = 2'b00;
  localparam logic [1:0] R_ERROR = 2'b01;
  localparam logic [1:0] R_RETRY = 2'b10;
  localparam logic [1:0] R_SPLIT = 2'b11;

  localparam logic [1:0] BUSY_CODE =
    SPLIT_EN ? R_SPLIT : R_RETRY;
  localparam logic [3:0] WS_LOAD =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              wr_q, wr_d;
  logic              ok_q, ok_d;
  logic [1:0]        code_q, code_d;
  logic [15:0]       mask_q, mask_d;
  logic [15:0]       hsplit_q, hsplit_d;

  logic [31:0]       mem_q [DEPTH];

  logic [ADDR_W-1:0] idx_a;
  logic              accept;
  logic              bad;
  logic              wr_en;
  logic              unused_bits;

  assign idx_a  = HADDR[ADDR_W+1:2];
  assign accept = HSEL & HREADY & HTRANS[1] &
                  ((state_q == ST_READY) | (state_q == ST_RESP2));
  assign bad    = (HSIZE != 3'b010) | (HADDR[1:0] != 2'b00) |
                  ({1'b0, idx_a} >= DEPTH_L);
  assign wr_en  = (state_q == ST_READY) & ok_q & wr_q;

  assign unused_bits = ^{HBURST, HTRANS[0], HADDR[31:ADDR_W+2]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    ok_d     = ok_q;
    code_d   = code_q;
    mask_d   = mask_q;
    hsplit_d = 16'h0;

    unique case (state_q)
      ST_READY: ok_d = 1'b0;
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_READY;
        else cnt_d = cnt_q - 4'd1;
      end
      ST_RESP1: state_d = ST_RESP2;
      ST_RESP2: state_d = ST_READY;
      default:  state_d = ST_READY;
    endcase

    // Release and capture never coincide: capture needs busy high.
    if (!split_busy && (mask_q != 16'h0)) begin
      hsplit_d = mask_q;
      mask_d   = 16'h0;
    end

    if (accept) begin
      idx_d = idx_a;
      wr_d  = HWRITE;
      ok_d  = 1'b0;
      if (bad) begin
        state_d = ST_RESP1;
        code_d  = R_ERROR;
      end else if (split_busy) begin
        state_d = ST_RESP1;
        code_d  = BUSY_CODE;
        if (SPLIT_EN) mask_d[HMASTER] = 1'b1;
      end else begin
        ok_d   = 1'b1;
        code_d = R_OKAY;
        if (WAIT_STATES > 0) begin
          state_d = ST_WAIT;
          cnt_d   = WS_LOAD;
        end else begin
          state_d = ST_READY;
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q  <= ST_READY;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      ok_q     <= 1'b0;
      code_q   <= R_OKAY;
      mask_q   <= 16'h0;
      hsplit_q <= 16'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      ok_q     <= ok_d;
      code_q   <= code_d;
      mask_q   <= mask_d;
      hsplit_q <= hsplit_d;
    end
  end

  // Asynchronous read of the flop array makes a write on the
  // accepting edge visible to the following read data phase.
  always_ff @(posedge HCLK) begin
    if (wr_en) mem_q[idx_q] <= HWDATA;
  end

  always_comb begin
    HREADYOUT = (state_q == ST_READY) | (state_q == ST_RESP2);
    HRESP     = R_OKAY;
    HRDATA    = 32'h0;
    if ((state_q == ST_RESP1) | (state_q == ST_RESP2))
      HRESP = code_q;
    if (ok_q & ~wr_q &
        ((state_q == ST_READY) | (state_q == ST_WAIT)))
      HRDATA = mem_q[idx_q];
  end

  assign HSPLIT = hsplit_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Randomized and directed bench for ahb_slave_mem; two instances
// (0 waits/SPLIT and 2 waits/RETRY) checked against an array model.
module tb_ahb_slave_mem;

  localparam int DEP = 48;

  logic        clk;
  logic        rst_n;
  logic        sel_v;
  int          tgt;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [3:0]  hmaster;
  logic        busy;

  logic [31:0] rd  [2];
  logic        rdy [2];
  logic [1:0]  rsp [2];
  logic [15:0] spl [2];
  logic        hsel0, hsel1;

  assign hsel0 = sel_v && (tgt == 0);
  assign hsel1 = sel_v && (tgt == 1);

  ahb_slave_mem #(
    .ADDR_W(6), .DEPTH(DEP), .WAIT_STATES(0), .SPLIT_EN(1'b1)
  ) u_dut0 (
    .HCLK(clk), .HRESETN(rst_n), .HSEL(hsel0), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(hburst), .HWDATA(hwdata), .HMASTER(hmaster),
    .HREADY(rdy[0]), .split_busy(busy), .HRDATA(rd[0]),
    .HREADYOUT(rdy[0]), .HRESP(rsp[0]), .HSPLIT(spl[0])
  );

  ahb_slave_mem #(
    .ADDR_W(6), .DEPTH(DEP), .WAIT_STATES(2), .SPLIT_EN(1'b0)
  ) u_dut1 (
    .HCLK(clk), .HRESETN(rst_n), .HSEL(hsel1), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(hburst), .HWDATA(hwdata), .HMASTER(hmaster),
    .HREADY(rdy[1]), .split_busy(busy), .HRDATA(rd[1]),
    .HREADYOUT(rdy[1]), .HRESP(rsp[1]), .HSPLIT(spl[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mdl   [2][DEP];
  bit          known [2][DEP];
  int          ws    [2] = '{0, 2};
  int          n_chk = 0;
  int          n_bad = 0;

  bit          p_w [8];
  logic [31:0] p_a [8];
  logic [31:0] p_d [8];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    sel_v  = 1'b0;
    htrans = 2'b00;
    hburst = 3'b000;
  endtask

  // Single transfer; starts and ends just after a falling edge.
  task automatic xfer(input int t, input bit w, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] d,
                      input bit bz, input logic [3:0] m);
    int          idx;
    int          waits;
    bit          bad;
    bit          done;
    logic [1:0]  lowr, endr, expc;
    logic [31:0] rdv;
    tgt = t; sel_v = 1'b1; haddr = a; htrans = 2'b10;
    hwrite = w; hsize = sz; hmaster = m; busy = bz;
    hburst = 3'b000;
    @(posedge clk); @(negedge clk);
    idle_bus();
    hwdata = d;
    waits = 0; lowr = 2'b00; endr = 2'b00; rdv = 32'h0; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (rdy[t]) begin
        done = 1; endr = rsp[t]; rdv = rd[t];
      end else begin
        if (waits == 0) lowr = rsp[t];
        waits++;
        @(negedge clk);
      end
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
    idx  = int'(a[7:2]);
    bad  = (sz != 3'b010) || (a[1:0] != 2'b00) || (idx >= DEP);
    expc = bad ? 2'b01 : bz ? ((t == 0) ? 2'b11 : 2'b10) : 2'b00;
    chk("waits", waits, (expc != 2'b00) ? 1 : ws[t]);
    chk("resp", {30'd0, endr}, {30'd0, expc});
    if (expc != 2'b00) chk("resp_low", {30'd0, lowr}, {30'd0, expc});
    if (expc == 2'b00 && w) begin
      mdl[t][idx] = d; known[t][idx] = 1;
    end
    if (expc == 2'b00 && !w) begin
      if (known[t][idx]) chk("rdata", rdv, mdl[t][idx]);
    end else begin
      chk("rdata_zero", rdv, 32'h0);
    end
    if (bz) begin
      busy = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("hsplit", {16'h0, spl[t]},
          (t == 0 && !bad) ? (32'd1 << m) : 32'd0);
      @(posedge clk); @(negedge clk);
      chk("hsplit_clr", {16'h0, spl[t]}, 32'd0);
    end
  endtask

  // Pipelined zero-wait sequence on instance 0.
  task automatic pipe(input int n);
    int idx;
    tgt = 0; busy = 1'b0;
    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin
        idx = int'(p_a[i-1][7:2]);
        chk("p_rdy", {31'd0, rdy[0]}, 32'd1);
        chk("p_resp", {30'd0, rsp[0]}, 32'd0);
        if (p_w[i-1]) begin
          chk("p_rd0", rd[0], 32'h0);
          hwdata = p_d[i-1];
          mdl[0][idx] = p_d[i-1]; known[0][idx] = 1;
        end else if (known[0][idx]) begin
          chk("p_rdata", rd[0], mdl[0][idx]);
        end
      end
      if (i < n) begin
        sel_v = 1'b1; haddr = p_a[i];
        htrans = (i == 0) ? 2'b10 : 2'b11;
        hburst = 3'b011; hwrite = p_w[i]; hsize = 3'b010;
        hmaster = 4'd1;
      end else begin
        idle_bus();
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; tgt = 0; haddr = 0; hwrite = 0; hsize = 3'b010;
    hwdata = 0; hmaster = 0; busy = 0;
    idle_bus();
    for (int i = 0; i < DEP; i++) begin
      known[0][i] = 0; known[1][i] = 0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 2; t++) begin
      chk("rst_rdy", {31'd0, rdy[t]}, 32'd1);
      chk("rst_resp", {30'd0, rsp[t]}, 32'd0);
      chk("rst_rdata", rd[t], 32'h0);
      chk("rst_split", {16'h0, spl[t]}, 32'd0);
    end

    // INCR4 write at 0x24 then read back
    for (int i = 0; i < 4; i++) begin
      p_w[i] = 1; p_a[i] = 32'h24 + 32'(4 * i);
      p_d[i] = 32'h1000_0000 + 32'(i * 17);
    end
    pipe(4);
    for (int i = 0; i < 4; i++) p_w[i] = 0;
    pipe(4);

    xfer(1, 1, 32'h10, 3'b010, 32'hCAFE_0010, 0, 0);
    xfer(1, 0, 32'h10, 3'b010, 32'h0, 0, 0);

    // write then read of the same word, back to back
    p_w[0] = 1; p_a[0] = 32'h08; p_d[0] = 32'hA5A5_A5A5;
    p_w[1] = 0; p_a[1] = 32'h08; p_d[1] = 32'h0;
    pipe(2);
    chk("fwd_model", mdl[0][2], 32'hA5A5_A5A5);

    xfer(0, 1, 32'h00, 3'b010, 32'h0BAD_0000, 0, 0);
    xfer(0, 1, 32'hC0, 3'b010, 32'hFFFF_0001, 0, 0);
    xfer(0, 1, 32'h24, 3'b000, 32'hFFFF_0002, 0, 0);
    xfer(0, 1, 32'h02, 3'b010, 32'hFFFF_0003, 0, 0);
    xfer(1, 1, 32'hC0, 3'b010, 32'hFFFF_0004, 0, 0);
    xfer(0, 0, 32'h24, 3'b010, 32'h0, 0, 0);
    xfer(0, 0, 32'h00, 3'b010, 32'h0, 0, 0);

    xfer(0, 0, 32'h24, 3'b010, 32'h0, 1, 4'd2);
    xfer(1, 0, 32'h10, 3'b010, 32'h0, 1, 4'd2);

    // reset in the middle of a wait-state data phase
    tgt = 1; sel_v = 1'b1; haddr = 32'h10; htrans = 2'b10;
    hwrite = 1; hsize = 3'b010; hmaster = 0; busy = 0;
    @(posedge clk); @(negedge clk);
    idle_bus();
    hwdata = 32'hDEAD_0001;
    chk("rst_pre", {31'd0, rdy[1]}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rdy", {31'd0, rdy[1]}, 32'd1);
    chk("arst_resp", {30'd0, rsp[1]}, 32'd0);
    chk("arst_split", {16'h0, spl[1]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1, 0, 32'h10, 3'b010, 32'h0, 0, 0);
    xfer(1, 1, 32'h14, 3'b010, 32'h1234_5678, 0, 0);
    xfer(1, 0, 32'h14, 3'b010, 32'h0, 0, 0);

    for (int it = 0; it < 80; it++) begin
      int          t, k;
      bit          w, bz;
      logic [31:0] a;
      logic [2:0]  sz;
      t  = int'($urandom % 2);
      w  = 1'($urandom % 2);
      a  = 32'($urandom % 16) << 2;
      sz = 3'b010;
      k  = int'($urandom % 10);
      if (k == 0) sz = 3'($urandom % 8) & 3'b101;
      if (k == 1) a = a | 32'd2;
      if (k == 2) a = 32'(DEP * 4) + (32'($urandom % 16) << 2);
      bz = ($urandom % 6) == 0;
      xfer(t, w, a, sz, $urandom, bz, 4'($urandom % 16));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

Word-addressed AHB slave with an internal RAM. It is the responder for the bus masters and sits behind the address decoder and arbiter. It inserts a programmable number of wait states and returns two-cycle ERROR responses for illegal accesses. When a back-end busy input is high, it answers SPLIT (or RETRY), tracks the split masters, and releases them through HSPLIT once the back end is free.

## Interface
Parameters:
- ADDR_W, 6, word-index width; index = HADDR[ADDR_W+1:2], higher HADDR bits ignored (decoder qualifies HSEL)
- DEPTH, 64, number of 32-bit words; DEPTH <= 2^ADDR_W
- WAIT_STATES, 0, HREADYOUT-low cycles inserted before each OKAY completion (0..15)
- SPLIT_EN, 1, 1 = busy answered with SPLIT, 0 = busy answered with RETRY

Ports:
- HCLK  in  1  bus clock, all state on rising edge
- HRESETN  in  1  asynchronous active-low reset
- HSEL  in  1  slave select from decoder
- HADDR  in  32  address
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size; only WORD=010 legal
- HBURST  in  3  burst type (informational, not used for address generation)
- HWDATA  in  32  write data
- HMASTER  in  4  current master number from arbiter
- HREADY  in  1  bus-level ready (end of previous data phase)
- split_busy  in  1  back end unavailable
- HRDATA  out  32  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  2  OKAY=00, ERROR=01, RETRY=10, SPLIT=11
- HSPLIT  out  16  one-hot-per-master split release

## Operation
- An address phase is accepted on a rising edge with HSEL=1, HREADY=1 and HTRANS[1]=1. The slave registers address index, HWRITE and HMASTER, and the data phase starts next cycle.
- IDLE/BUSY transfers, or HSEL=0 with HREADY=1: no action. The next cycle is a zero-wait OKAY (HREADYOUT=1, HRESP=OKAY).
- Classification at acceptance, in priority order:
  - HSIZE!=010, HADDR[1:0]!=0, or index>=DEPTH: ERROR.
  - split_busy=1: SPLIT if SPLIT_EN, else RETRY.
  - Otherwise: OKAY.
- FSM states:
  - READY: HREADYOUT=1, HRESP=OKAY.
  - WAIT: HREADYOUT=0, HRESP=OKAY. Counter loads WAIT_STATES-1 and decrements.
  - RESP1: HREADYOUT=0, HRESP=code.
  - RESP2: HREADYOUT=1, HRESP=code.
- Transitions:
  - Accepted OKAY with WAIT_STATES>0: READY→WAIT. WAIT→READY when the counter reaches 0.
  - Accepted OKAY with WAIT_STATES=0: stay in READY.
  - ERROR/RETRY/SPLIT: →RESP1→RESP2.
  - RESP2, or READY with HREADYOUT=1, may accept the next address phase on the same edge.
- Write: mem[index] <= HWDATA on the edge that ends the data phase (HREADYOUT=1, OKAY). No write on ERROR/RETRY/SPLIT.
- Read: HRDATA is driven from mem[index] while in the data phase. If the previous data phase wrote the same index on the edge that accepted this read, HWDATA is forwarded. HRDATA is 0 outside read OKAY data phases.
- Split tracking: a 16-bit pending mask. A SPLIT response sets bit HMASTER at RESP1 entry. When split_busy=0 and mask!=0, HSPLIT=mask for exactly one cycle (registered) and the mask clears on the same edge. Duplicate splits of one master merge.
- No transfer is accepted while in WAIT/RESP1. The bus protocol guarantees HREADY=0 there.

## Timing
- Reset values: HREADYOUT=1, HRESP=OKAY, HRDATA=0, HSPLIT=0, FSM=READY, mask=0, wait counter=0. Memory contents are not reset.
- Reset asserted mid-transfer: outputs take their reset values immediately (asynchronously). A pending write is dropped and split masters are not released.
- OKAY latency: WAIT_STATES+1 data-phase cycles.
- Error/retry/split latency: always 2 cycles (RESP1, RESP2), independent of WAIT_STATES.
- HSPLIT: asserted the cycle after the first edge sampling split_busy=0 with a non-empty mask; deasserted the following cycle.
- split_busy rising during a WAIT data phase does not affect that transfer. It is sampled only at address acceptance.

## Test plan
- Write burst INCR4 at 0x24, WAIT_STATES=0, then read back → data phases complete with HREADYOUT=1, HRESP=00, and HRDATA returns the written words in order.
- WAIT_STATES=2, single write then read of 0x10 → exactly 2 cycles of HREADYOUT=0 per transfer, then OKAY with correct data.
- Back-to-back write 0x08 = 0xA5A5A5A5 then read 0x08 with zero waits → HRDATA=0xA5A5A5A5 (forwarding path).
- Access at index DEPTH, HSIZE=000, or HADDR=0x02 → HRESP=01 with HREADYOUT 0 then 1, and memory unchanged.
- SPLIT_EN=1, split_busy=1, master 2 NONSEQ → HRESP=11 for two cycles. Drop split_busy → HSPLIT=0x0004 for one cycle. With SPLIT_EN=0 the same stimulus → HRESP=10 and HSPLIT stays 0.
- HRESETN pulled low during a WAIT cycle → HREADYOUT=1, HRESP=00, HSPLIT=0 immediately, and the next transfer completes normally.
